cpu_trace_serializer: RTL

Upstream producer for `cpu_checker`. Accepts one retired-instruction trace record per handshake and serializes it as ASCII, one character per clock on `char`, in the exact textual form the checker parses. A register write (`is_mem=0`) is emitted as `^T@PPPPPPPP: $R <= DDDDDDDD#`. A memory write (`is_mem=1`) is emitted as `^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#`.

---
 rtl/cpu_trace_serializer_pkg.sv | 35 +++
 rtl/cpu_trace_serializer_nibble_to_ascii.sv | 17 +
 rtl/cpu_trace_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_serializer_pkg.sv
// Shared definitions for the trace serializer: ASCII constants and FSM state encoding.
package trace_defs;

    localparam logic [7:0] CH_NUL    = 8'h00;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_HEX0   = 8'h30;
    localparam logic [7:0] CH_HEXA   = 8'h61;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CARET,
        ST_TIME,
        ST_AT,
        ST_PC,
        ST_COLON,
        ST_SP0,
        ST_TGT,
        ST_TGTVAL,
        ST_SP1,
        ST_LT,
        ST_EQ,
        ST_SP2,
        ST_DATA,
        ST_HASH
    } state_t;

endpackage

// File: rtl/cpu_trace_serializer_nibble_to_ascii.sv
// Maps one nibble to its lowercase hex ASCII character.
module nibble_to_ascii
    import trace_defs::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_nib < 4'd10) begin
            o_ascii = CH_HEX0 + {4'h0, i_nib};
        end else begin
            o_ascii = CH_HEXA + {4'h0, i_nib} - 8'd10;
        end
    end

endmodule

// File: rtl/cpu_trace_serializer.sv
// Serializes one retired-instruction trace record per handshake into ASCII text,
// one character per clock, in the form parsed by the downstream checker.
module cpu_trace_serializer
    import trace_defs::*;
#(
    parameter int unsigned TIME_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     is_mem,
    input  logic [4*TIME_DIGITS-1:0] time_bcd,
    input  logic [31:0]              pc,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              data,
    output logic [7:0]               char,
    output logic                     char_valid
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [2:0]               r_cnt;
    logic [2:0]               w_next_cnt;
    logic                     r_is_mem;
    logic [4*TIME_DIGITS-1:0] r_time;
    logic [31:0]              r_pc;
    logic [4:0]               r_grf;
    logic [31:0]              r_mem_addr;
    logic [31:0]              r_data;
    logic [7:0]               r_char;
    logic                     r_char_valid;

    logic       w_accept;
    logic [2:0] w_time_first;
    logic       w_grf_two;
    logic [3:0] w_tens;
    logic [4:0] w_ones;
    logic [2:0] w_tgt_last;
    logic [3:0] w_nib;
    logic [7:0] w_hex;
    logic [7:0] w_next_char;

    assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_HASH);
    assign w_accept   = in_valid && in_ready;
    assign char       = r_char;
    assign char_valid = r_char_valid;

    // First non-zero time digit (MS-first index); all-zero time still prints the last digit.
    always_comb begin
        w_time_first = 3'(TIME_DIGITS - 1);
        for (int unsigned k = 0; k < TIME_DIGITS; k++) begin
            if (r_time[4*k +: 4] != 4'd0) begin
                w_time_first = 3'(TIME_DIGITS - 1 - k);
            end
        end
    end

    always_comb begin
        if (r_grf >= 5'd30) begin
            w_tens = 4'd3;
            w_ones = r_grf - 5'd30;
        end else if (r_grf >= 5'd20) begin
            w_tens = 4'd2;
            w_ones = r_grf - 5'd20;
        end else if (r_grf >= 5'd10) begin
            w_tens = 4'd1;
            w_ones = r_grf - 5'd10;
        end else begin
            w_tens = 4'd0;
            w_ones = r_grf;
        end
    end

    assign w_grf_two  = (r_grf >= 5'd10);
    assign w_tgt_last = r_is_mem ? 3'd7 : {2'b00, w_grf_two};

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_HASH: begin
                w_next_state = w_accept ? ST_CARET : ST_IDLE;
                w_next_cnt   = '0;
            end
            ST_CARET: begin
                w_next_state = ST_TIME;
                w_next_cnt   = w_time_first;
            end
            ST_TIME: begin
                if (r_cnt == 3'(TIME_DIGITS - 1)) begin
                    w_next_state = ST_AT;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            ST_AT:    w_next_state = ST_PC;
            ST_PC: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = ST_COLON;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            ST_COLON: w_next_state = ST_SP0;
            ST_SP0:   w_next_state = ST_TGT;
            ST_TGT: begin
                w_next_state = ST_TGTVAL;
                w_next_cnt   = '0;
            end
            ST_TGTVAL: begin
                if (r_cnt == w_tgt_last) begin
                    w_next_state = ST_SP1;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            ST_SP1:   w_next_state = ST_LT;
            ST_LT:    w_next_state = ST_EQ;
            ST_EQ:    w_next_state = ST_SP2;
            ST_SP2: begin
                w_next_state = ST_DATA;
                w_next_cnt   = '0;
            end
            ST_DATA: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = ST_HASH;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 3'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Output is registered, so the character is chosen from the state being entered.
    always_comb begin
        w_nib = '0;
        case (w_next_state)
            ST_TIME: w_nib = r_time[4*(TIME_DIGITS - 1 - 32'(w_next_cnt)) +: 4];
            ST_PC:   w_nib = r_pc[{~w_next_cnt, 2'b00} +: 4];
            ST_DATA: w_nib = r_data[{~w_next_cnt, 2'b00} +: 4];
            ST_TGTVAL: begin
                if (r_is_mem) begin
                    w_nib = r_mem_addr[{~w_next_cnt, 2'b00} +: 4];
                end else if (w_grf_two && (w_next_cnt == 3'd0)) begin
                    w_nib = w_tens;
                end else begin
                    w_nib = 4'(w_ones);
                end
            end
            default: w_nib = '0;
        endcase
    end

    nibble_to_ascii u_nib (
        .i_nib   (w_nib),
        .o_ascii (w_hex)
    );

    always_comb begin
        w_next_char = CH_NUL;
        case (w_next_state)
            ST_CARET:                   w_next_char = CH_CARET;
            ST_TIME, ST_PC,
            ST_TGTVAL, ST_DATA:         w_next_char = w_hex;
            ST_AT:                      w_next_char = CH_AT;
            ST_COLON:                   w_next_char = CH_COLON;
            ST_SP0, ST_SP1, ST_SP2:     w_next_char = CH_SPACE;
            ST_TGT:                     w_next_char = r_is_mem ? CH_STAR : CH_DOLLAR;
            ST_LT:                      w_next_char = CH_LT;
            ST_EQ:                      w_next_char = CH_EQ;
            ST_HASH:                    w_next_char = CH_HASH;
            default:                    w_next_char = CH_NUL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_char       <= '0;
            r_char_valid <= 1'b0;
            r_is_mem     <= 1'b0;
            r_time       <= '0;
            r_pc         <= '0;
            r_grf        <= '0;
            r_mem_addr   <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_char       <= w_next_char;
            r_char_valid <= (w_next_state != ST_IDLE);
            if (w_accept) begin
                r_is_mem   <= is_mem;
                r_time     <= time_bcd;
                r_pc       <= pc;
                r_grf      <= grf_addr;
                r_mem_addr <= mem_addr;
                r_data     <= data;
            end
        end
    end

endmodule
